// File: rtl/baud_tick_gen.sv
// Programmable UART baud tick generator: oversample tick, bit tick, counted bursts.
// Optional fractional division is compiled in when BAUD_FRAC_EN is defined.
module baud_tick_gen #(
  parameter int CLK_FREQ    = 25000000,
  parameter int BAUD        = 9600,
  parameter int OVERSAMPLE  = 16,
  parameter int DIV_W       = 16,
  parameter int CNT_W       = 8,
  parameter int DIV_DEFAULT = CLK_FREQ / (BAUD * OVERSAMPLE)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             div_load,
  input  logic [DIV_W-1:0] div_value,
  input  logic             burst_mode,
  input  logic             start,
  input  logic [CNT_W-1:0] burst_len,
`ifdef BAUD_FRAC_EN
  input  logic [3:0]       frac_value,
`endif
  output logic             tick_os,
  output logic             tick_bit,
  output logic             busy,
  output logic             done
);

  localparam int OS_W = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;
  localparam logic [DIV_W-1:0] DIV_RESET = (DIV_DEFAULT < 2) ? DIV_W'(2) : DIV_W'(DIV_DEFAULT);
  localparam logic [OS_W-1:0]  OS_LAST   = OS_W'(OVERSAMPLE - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] clk_cnt_q, clk_cnt_d;
  logic [OS_W-1:0]  os_cnt_q, os_cnt_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic             tick_os_q, tick_os_d;
  logic             tick_bit_q, tick_bit_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             running;
  logic             burst_start;
  logic             last_bit;
  logic [DIV_W-1:0] terminal;

`ifdef BAUD_FRAC_EN
  logic [3:0] frac_acc_q, frac_acc_d;
  logic       stretch_q, stretch_d;
  logic [4:0] frac_sum;

  // A carry out of the accumulator lengthens the following os period by one clk.
  assign terminal = stretch_q ? div_q : div_q - DIV_W'(1);
  assign frac_sum = {1'b0, frac_acc_q} + {1'b0, frac_value};
`else
  assign terminal = div_q - DIV_W'(1);
`endif

  assign running     = enable & (burst_mode ? (state_q == RUN) : 1'b1);
  assign burst_start = burst_mode & start;

  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    clk_cnt_d  = clk_cnt_q;
    os_cnt_d   = os_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    tick_os_d  = 1'b0;
    tick_bit_d = 1'b0;
    done_d     = 1'b0;
    last_bit   = 1'b0;
`ifdef BAUD_FRAC_EN
    frac_acc_d = frac_acc_q;
    stretch_d  = stretch_q;
`endif

    if (div_load) begin
      div_d     = (div_value < DIV_W'(2)) ? DIV_W'(2) : div_value;
      clk_cnt_d = '0;
      os_cnt_d  = '0;
`ifdef BAUD_FRAC_EN
      frac_acc_d = '0;
      stretch_d  = 1'b0;
`endif
    end else if (running) begin
      if (clk_cnt_q == terminal) begin
        clk_cnt_d = '0;
        tick_os_d = 1'b1;
`ifdef BAUD_FRAC_EN
        frac_acc_d = frac_sum[3:0];
        stretch_d  = frac_sum[4];
`endif
        if (os_cnt_q == OS_LAST) begin
          os_cnt_d   = '0;
          tick_bit_d = 1'b1;
          if (burst_mode && state_q == RUN) begin
            bit_cnt_d = bit_cnt_q - CNT_W'(1);
            if (bit_cnt_q == CNT_W'(1)) begin
              done_d   = 1'b1;
              last_bit = 1'b1;
              state_d  = IDLE;
            end
          end
        end else begin
          os_cnt_d = os_cnt_q + OS_W'(1);
        end
      end else begin
        clk_cnt_d = clk_cnt_q + DIV_W'(1);
      end
    end

    if (!burst_mode) begin
      state_d = IDLE;
    end

    // A start (re)launches the burst from a clean phase and overrides any tick this cycle.
    if (burst_start) begin
      clk_cnt_d  = '0;
      os_cnt_d   = '0;
      tick_os_d  = 1'b0;
      tick_bit_d = 1'b0;
      last_bit   = 1'b0;
`ifdef BAUD_FRAC_EN
      frac_acc_d = '0;
      stretch_d  = 1'b0;
`endif
      if (burst_len == '0) begin
        state_d   = IDLE;
        bit_cnt_d = '0;
        done_d    = 1'b1;
      end else begin
        state_d   = RUN;
        bit_cnt_d = burst_len;
        done_d    = 1'b0;
      end
    end

    // busy stays high through the cycle carrying the final tick_bit and done.
    busy_d = (state_d == RUN) | last_bit;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      div_q      <= DIV_RESET;
      clk_cnt_q  <= '0;
      os_cnt_q   <= '0;
      bit_cnt_q  <= '0;
      tick_os_q  <= 1'b0;
      tick_bit_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      clk_cnt_q  <= clk_cnt_d;
      os_cnt_q   <= os_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      tick_os_q  <= tick_os_d;
      tick_bit_q <= tick_bit_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

`ifdef BAUD_FRAC_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frac_acc_q <= '0;
      stretch_q  <= 1'b0;
    end else begin
      frac_acc_q <= frac_acc_d;
      stretch_q  <= stretch_d;
    end
  end
`endif

  assign tick_os  = tick_os_q;
  assign tick_bit = tick_bit_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule
